// File: rtl/onchip_reader_pkg.sv
// Shared types and defaults for the on-chip memory stream reader.
// Build option: define ONCHIP_READER_LOOP_EN to make the reader loop over
// its word range until stopped, instead of running it once.
package onchip_reader_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 64;
    localparam int PIX_W_DEF  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int fifo_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/onchip_reader_fifo.sv
// Synchronous word FIFO between the memory read port and the half-word
// unpacker. Flush clears occupancy in one cycle; the head word is read
// combinationally so it is visible the cycle after it was pushed.
module onchip_reader_fifo
    import onchip_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    input  logic                               push_i,
    input  logic [DATA_W-1:0]                  wdata_i,
    input  logic                               pop_i,
    output logic [DATA_W-1:0]                  rdata_o,
    output logic [fifo_count_width(DEPTH)-1:0] count_o,
    output logic                               empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = fifo_count_width(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              push_ok_s;
    logic              pop_ok_s;

    // A pop on an empty FIFO or a push into a full one (without a pop) is dropped.
    assign pop_ok_s  = pop_i & (count_q != CW'(0));
    assign push_ok_s = push_i & ((count_q != CW'(DEPTH)) | pop_ok_s);

    // Storage array; no reset needed since occupancy qualifies every read.
    always_ff @(posedge clk_i) begin
        if (push_ok_s && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping with flush taking priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
        end else if (flush_i) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == CW'(0));

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master that streams a contiguous range of 64-bit on-chip
// RAM words out as 32-bit elements, low half first.
// Build option: ONCHIP_READER_LOOP_EN wraps the issue address back to the
// base after the last word and keeps reading until stop.
module onchip_mem_stream_reader
    import onchip_reader_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int PIX_W      = PIX_W_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       word_count,
    input  logic                  stop,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic                  out_valid,
    output logic [PIX_W-1:0]      out_data,
    input  logic                  out_ready
);

    localparam int CW    = fifo_count_width(FIFO_DEPTH);
    localparam int CNT_W = ADDR_W + 1;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  issued_q;
    logic [CNT_W-1:0]  count_q;
    logic              inflight_q;
    logic              half_q;
    logic              done_q;
`ifdef ONCHIP_READER_LOOP_EN
    logic [ADDR_W-1:0] base_q;
`endif

    logic [DATA_W-1:0] fifo_rdata_s;
    logic [CW-1:0]     fifo_count_s;
    logic              fifo_empty_s;
    logic              flush_s;
    logic              push_s;
    logic              accept_s;
    logic              pop_s;
    logic              last_issue_s;

    // Abort only matters while a run is active; it discards everything buffered.
    assign flush_s      = stop & (state_q != ST_IDLE);
    // Read data is always captured the cycle after its strobe unless aborted.
    assign push_s       = inflight_q & ~flush_s;
    assign accept_s     = out_valid & out_ready;
    assign pop_s        = accept_s & half_q;
    assign last_issue_s = (issued_q + CNT_W'(1)) == count_q;

    // Credit check counts the read already on the bus so the FIFO never overflows.
    assign mem_chipselect = (state_q == ST_RUN) & ~stop &
                            ((fifo_count_s + CW'(inflight_q)) < CW'(FIFO_DEPTH));
    assign mem_address    = addr_q;
    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;
    assign mem_clken      = 1'b1;

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign out_valid = ~fifo_empty_s;

    // Select the current half of the head word; drive zero when nothing is valid.
    always_comb begin
        out_data = {PIX_W{1'b0}};
        if (out_valid) begin
            if (half_q) begin
                out_data = fifo_rdata_s[DATA_W-1:PIX_W];
            end else begin
                out_data = fifo_rdata_s[PIX_W-1:0];
            end
        end else begin
            out_data = {PIX_W{1'b0}};
        end
    end

    onchip_reader_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .flush_i (flush_s),
        .push_i  (push_s),
        .wdata_i (mem_readdata),
        .pop_i   (pop_s),
        .rdata_o (fifo_rdata_s),
        .count_o (fifo_count_s),
        .empty_o (fifo_empty_s)
    );

    // Control FSM: command capture, address/issue counting, unpack phase, done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= ADDR_W'(0);
            issued_q   <= CNT_W'(0);
            count_q    <= CNT_W'(0);
            inflight_q <= 1'b0;
            half_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef ONCHIP_READER_LOOP_EN
            base_q     <= ADDR_W'(0);
`endif
        end else begin
            done_q     <= 1'b0;
            inflight_q <= mem_chipselect;

            if (flush_s) begin
                half_q <= 1'b0;
            end else if (accept_s) begin
                half_q <= ~half_q;
            end else begin
                half_q <= half_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        if (word_count == CNT_W'(0)) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q  <= ST_RUN;
                            addr_q   <= base_addr;
                            issued_q <= CNT_W'(0);
                            count_q  <= word_count;
`ifdef ONCHIP_READER_LOOP_EN
                            base_q   <= base_addr;
`endif
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                    end else if (mem_chipselect) begin
                        if (last_issue_s) begin
`ifdef ONCHIP_READER_LOOP_EN
                            addr_q   <= base_q;
                            issued_q <= CNT_W'(0);
`else
                            state_q  <= ST_DRAIN;
`endif
                        end else begin
                            addr_q   <= addr_q + ADDR_W'(1);
                            issued_q <= issued_q + CNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                    end else if (pop_s && (fifo_count_s == CW'(1)) && !inflight_q) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Self-checking bench for onchip_mem_stream_reader with a 1-cycle-latency
// memory model and a scoreboard of expected stream elements and addresses.
module tb_onchip_mem_stream_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [12:0] base_addr;
    logic [13:0] word_count;
    logic        stop;
    logic        busy;
    logic        done;
    logic [12:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [7:0]  mem_byteenable;
    logic        mem_clken;
    logic [63:0] mem_readdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    logic [31:0] dq [$];
    logic [12:0] aq [$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int cs_cnt = 0;
    int acc_cnt = 0;

    always #5 clk = ~clk;

    onchip_mem_stream_reader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .stop           (stop),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready)
    );

    // Memory model: word[i] = {2i+1, 2i}, valid one cycle after the strobe.
    always @(posedge clk) begin
        int a;
        a = int'(mem_address);
        if (mem_chipselect) mem_readdata <= {32'(2 * a + 1), 32'(2 * a)};
        else                mem_readdata <= 64'hBAD0_BAD0_BAD0_BAD0;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard monitor away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) begin
                acc_cnt++;
                if (dq.size() == 0) check_eq("elem_unexpected", out_valid, 1'b0);
                else                check_eq("stream_data", out_data, dq.pop_front());
            end
            if (mem_chipselect) begin
                cs_cnt++;
                if (aq.size() == 0) check_eq("read_unexpected", mem_chipselect, 1'b0);
                else                check_eq("mem_address", mem_address, aq.pop_front());
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_run(input int base, input int cnt, input int period);
        for (int i = 0; i < cnt; i++) begin
            int a;
            a = (base + (i % period)) % 8192;
            aq.push_back(13'(a));
            dq.push_back(32'(2 * a));
            dq.push_back(32'(2 * a + 1));
        end
    endtask

    task automatic issue_start(input int base, input int cnt);
        start      = 1'b1;
        base_addr  = 13'(base);
        word_count = 14'(cnt);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rand_ready);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
            if (done) seen = 1'b1;
        end
        check_eq("done_seen", seen, 1'b1);
        out_ready = 1'b1;
    endtask

    task automatic wait_accepts(input int target, input int budget);
        int n;
        n = 0;
        while (acc_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check_eq("accept_budget", acc_cnt >= target, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0;
        int d0;
        int a0;
        reset_n    = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        base_addr  = 13'd0;
        word_count = 14'd0;
        out_ready  = 1'b1;
        repeat (3) tick();
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_cs", mem_chipselect, 1'b0);
        check_eq("rst_addr", mem_address, 13'd0);
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_data", out_data, 32'd0);
        check_eq("tie_write", mem_write, 1'b0);
        check_eq("tie_be", mem_byteenable, 8'hFF);
        check_eq("tie_clken", mem_clken, 1'b1);
        reset_n = 1'b1;
        repeat (2) tick();

`ifdef ONCHIP_READER_LOOP_EN
        // Looping run over two words until stopped.
        d0 = done_cnt;
        a0 = acc_cnt;
        expect_run(13'h100, 40, 2);
        issue_start(13'h100, 2);
        wait_accepts(a0 + 30, 200);
        check_eq("loop_busy", busy, 1'b1);
        stop = 1'b1;
        out_ready = 1'b0;
        dq.delete();
        aq.delete();
        tick();
        stop = 1'b0;
        check_eq("loop_stop_valid", out_valid, 1'b0);
        check_eq("loop_stop_busy", busy, 1'b0);
        check_eq("loop_no_done", done_cnt - d0, 0);
        out_ready = 1'b1;
        repeat (4) tick();
        check_eq("loop_quiet", out_valid, 1'b0);
`else
        // 1) Basic run: latency, 8 back-to-back elements, single done pulse.
        d0 = done_cnt;
        expect_run(13'h10, 4, 8192);
        issue_start(13'h10, 4);
        check_eq("t1_busy", busy, 1'b1);
        check_eq("t1_valid_e0", out_valid, 1'b0);
        tick();
        check_eq("t1_valid_e1", out_valid, 1'b0);
        tick();
        check_eq("t1_first_data", out_data, 32'h20);
        for (int i = 0; i < 8; i++) begin
            check_eq("t1_valid_run", out_valid, 1'b1);
            tick();
        end
        check_eq("t1_done", done, 1'b1);
        check_eq("t1_busy_end", busy, 1'b0);
        tick();
        check_eq("t1_done_pulse", done, 1'b0);
        check_eq("t1_done_count", done_cnt - d0, 1);

        // 2) Address wrap at the top of memory.
        expect_run(13'h1FFE, 4, 8192);
        issue_start(13'h1FFE, 4);
        wait_done(60, 1'b0);
        check_eq("t2_q_empty", dq.size() + aq.size(), 0);

        // 3) Backpressure: reads stop at FIFO capacity, no loss on resume.
        out_ready = 1'b0;
        c0 = cs_cnt;
        expect_run(13'h200, 64, 8192);
        issue_start(13'h200, 64);
        repeat (20) tick();
        check_eq("t3_reads_buffered", cs_cnt - c0, 8);
        check_eq("t3_cs_low", mem_chipselect, 1'b0);
        check_eq("t3_hold_valid", out_valid, 1'b1);
        check_eq("t3_hold_data", out_data, 32'h400);
        wait_done(1000, 1'b1);
        check_eq("t3_q_empty", dq.size() + aq.size(), 0);

        // 4) Abort mid-run, then a clean restart.
        out_ready = 1'b1;
        a0 = acc_cnt;
        expect_run(13'h40, 16, 8192);
        issue_start(13'h40, 16);
        wait_accepts(a0 + 5, 100);
        stop = 1'b1;
        out_ready = 1'b0;
        dq.delete();
        aq.delete();
        tick();
        stop = 1'b0;
        check_eq("t4_stop_valid", out_valid, 1'b0);
        check_eq("t4_stop_busy", busy, 1'b0);
        d0 = done_cnt;
        c0 = cs_cnt;
        out_ready = 1'b1;
        repeat (5) tick();
        check_eq("t4_no_done", done_cnt - d0, 0);
        check_eq("t4_no_reads", cs_cnt - c0, 0);
        expect_run(0, 2, 8192);
        issue_start(0, 2);
        wait_done(40, 1'b0);
        check_eq("t4_q_empty", dq.size() + aq.size(), 0);

        // 5) Zero-length command, then start ignored while busy.
        c0 = cs_cnt;
        d0 = done_cnt;
        issue_start(13'h55, 0);
        check_eq("t5_zero_done", done, 1'b1);
        check_eq("t5_zero_busy", busy, 1'b0);
        tick();
        check_eq("t5_zero_done_end", done, 1'b0);
        check_eq("t5_zero_reads", cs_cnt - c0, 0);
        expect_run(13'h300, 4, 8192);
        issue_start(13'h300, 4);
        tick();
        issue_start(13'h500, 4);
        wait_done(60, 1'b0);
        check_eq("t5_done_count", done_cnt - d0, 2);
        check_eq("t5_q_empty", dq.size() + aq.size(), 0);
        tick();
        check_eq("t5_idle_busy", busy, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
